// File: rtl/serial_chunk_comparator_if.sv
// Operator-side bundle of the serial chunk comparator.
//   pb, y, signed_mode : load button level, switch-bank chunk, compare mode
//   phase              : 0 LOAD_A, 1 LOAD_B, 2 CMP, 3 DONE
//   lout/gout/eout     : A<B / A>B / A==B, meaningful only while done=1
//   done               : high while the result is being displayed
// master = the board/operator side, slave = the comparator.
interface serial_chunk_comparator_if #(
  parameter int CHUNK = 4
);
  logic             pb;
  logic [CHUNK-1:0] y;
  logic             signed_mode;
  logic [1:0]       phase;
  logic             lout;
  logic             gout;
  logic             eout;
  logic             done;

  modport master (
    output pb, y, signed_mode,
    input  phase, lout, gout, eout, done
  );

  modport slave (
    input  pb, y, signed_mode,
    output phase, lout, gout, eout, done
  );
endinterface

// File: rtl/serial_chunk_comparator.sv
// Chunk-serial magnitude comparator.
// Two WIDTH-bit operands are entered CHUNK bits at a time (MSB chunk first)
// from a shared switch bank, one chunk per rising edge of the load button.
// The compare then walks the chunk pairs MSB-first, one per cycle, stopping
// at the first difference. Signed mode resolves differing sign bits in the
// first compare cycle; with equal signs the unsigned chunk walk is already
// the correct two's-complement ordering.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : serial_chunk_comparator_if.slave (pb, y, signed_mode in;
//          phase, lout, gout, eout, done out)
module serial_chunk_comparator #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_chunk_comparator_if.slave    bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CMP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mode_q, mode_d;
  logic               lout_q, lout_d;
  logic               gout_q, gout_d;
  logic               eout_q, eout_d;
  logic               pb_q;
  logic               ld;
  logic [CHUNK-1:0]   ca, cb;

  // Chunk idx counted from the LSB end of the operand.
  function automatic logic [CHUNK-1:0] chunk_of(input logic [WIDTH-1:0] v,
                                                input logic [CW-1:0]    idx);
    return v[int'(idx)*CHUNK +: CHUNK];
  endfunction

  // The button is already debounced; one registered copy gives the edge.
  assign ld = bus.pb & ~pb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      lout_q  <= 1'b0;
      gout_q  <= 1'b0;
      eout_q  <= 1'b0;
      pb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      lout_q  <= lout_d;
      gout_q  <= gout_d;
      eout_q  <= eout_d;
      pb_q    <= bus.pb;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    lout_d  = lout_q;
    gout_d  = gout_q;
    eout_d  = eout_q;
    ca      = chunk_of(a_q, cnt_q);
    cb      = chunk_of(b_q, cnt_q);

    case (state_q)
      LOAD_A: begin
        if (ld) begin
          // cnt counts chunks already entered, so MSB chunk lands first.
          a_d[int'(LAST - cnt_q)*CHUNK +: CHUNK] = bus.y;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      LOAD_B: begin
        if (ld) begin
          b_d[int'(LAST - cnt_q)*CHUNK +: CHUNK] = bus.y;
          if (cnt_q == LAST) begin
            // The compare walks down from the MSB chunk; the mode is
            // frozen here so later switch changes cannot disturb it.
            cnt_d   = LAST;
            mode_d  = bus.signed_mode;
            state_d = CMP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      CMP: begin
        // cnt == LAST only on the first compare cycle.
        if (mode_q && (cnt_q == LAST) && (a_q[WIDTH-1] != b_q[WIDTH-1])) begin
          lout_d  = a_q[WIDTH-1];
          gout_d  = ~a_q[WIDTH-1];
          state_d = DONE;
        end else if (ca > cb) begin
          gout_d  = 1'b1;
          state_d = DONE;
        end else if (ca < cb) begin
          lout_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          eout_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        // A press here starts the next operand pair immediately, so that
        // press already carries A's MSB chunk.
        if (ld) begin
          lout_d = 1'b0;
          gout_d = 1'b0;
          eout_d = 1'b0;
          a_d[(NCHUNK-1)*CHUNK +: CHUNK] = bus.y;
          if (NCHUNK == 1) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d   = CW'(1);
            state_d = LOAD_A;
          end
        end
      end

      default: state_d = LOAD_A;
    endcase
  end

  assign bus.phase = state_q;
  assign bus.lout  = lout_q;
  assign bus.gout  = gout_q;
  assign bus.eout  = eout_q;
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_chunk_comparator.sv
module tb_serial_chunk_comparator;

  logic       clk = 1'b0;
  logic       rst8, rst12;
  logic       pb;
  logic [3:0] y;
  logic       sm;
  int         w = 8;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_chunk_comparator_if #(.CHUNK(4)) if8 ();
  serial_chunk_comparator_if #(.CHUNK(4)) if12 ();

  assign if8.pb           = pb;
  assign if8.y            = y;
  assign if8.signed_mode  = sm;
  assign if12.pb          = pb;
  assign if12.y           = y;
  assign if12.signed_mode = sm;

  serial_chunk_comparator #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8)
  );

  serial_chunk_comparator #(.WIDTH(12), .CHUNK(4)) dut12 (
    .clk (clk),
    .rst (rst12),
    .bus (if12)
  );

  // Observe whichever instance is currently selected by w.
  logic [1:0] o_phase;
  logic       o_l, o_g, o_e, o_d;
  assign o_phase = (w == 12) ? if12.phase : if8.phase;
  assign o_l     = (w == 12) ? if12.lout  : if8.lout;
  assign o_g     = (w == 12) ? if12.gout  : if8.gout;
  assign o_e     = (w == 12) ? if12.eout  : if8.eout;
  assign o_d     = (w == 12) ? if12.done  : if8.done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, then release only the one under test.
  task automatic select(input int width);
    w    = width;
    rst8 = 1'b1; rst12 = 1'b1;
    pb = 1'b0; y = 4'h0; sm = 1'b0;
    step(); step();
    rst8  = (width != 8);
    rst12 = (width != 12);
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    y  = v;
    pb = 1'b1;
    repeat (hold) step();
    pb = 1'b0;
    step();
  endtask

  // i-th chunk counted from the MSB end.
  function automatic logic [3:0] ch(input logic [11:0] v, input int width, input int i);
    logic [11:0] s;
    s = v >> (width - 4 * (i + 1));
    return s[3:0];
  endfunction

  // Reference: result from integer ordering, latency from the position of
  // the first differing chunk (sign decision counts as the first cycle).
  // res: 0 = less, 1 = greater, 2 = equal.
  function automatic void model(input int width, input logic [11:0] a, input logic [11:0] b,
                                input bit smode, output int res, output int k);
    int av, bv, nch;
    nch = width / 4;
    av  = int'(a);
    bv  = int'(b);
    if (smode && a[width-1]) av = av - (1 << width);
    if (smode && b[width-1]) bv = bv - (1 << width);
    res = (av < bv) ? 0 : (av > bv) ? 1 : 2;
    k = nch;
    if (smode && (a[width-1] != b[width-1])) k = 1;
    else begin
      for (int i = nch - 1; i >= 0; i--)
        if (ch(a, width, i) != ch(b, width, i)) k = i + 1;
    end
  endfunction

  // Load A (optionally skipping its MSB chunk, already entered in DONE)
  // and B, then verify latency and result flags.
  task automatic run_cmp(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input bit smode, input bit noise, input bit skip_first);
    int nch, n, res, k;
    nch = w / 4;
    sm  = smode;
    for (int i = (skip_first ? 1 : 0); i < nch; i++) press(ch(a, w, i), 1);
    for (int i = 0; i < nch - 1; i++) press(ch(b, w, i), 1);
    y  = ch(b, w, nch - 1);
    pb = 1'b1;
    step();
    check({tag, "_entry_phase"}, 32'(o_phase), 32'd2);
    pb = 1'b0;
    n  = 0;
    while (!o_d && n < nch + 4) begin
      step();
      n++;
      if (noise) pb = ~pb;
    end
    pb = 1'b0;
    model(w, a, b, smode, res, k);
    check({tag, "_latency"}, 32'(n), 32'(k));
    check({tag, "_flags"}, {28'd0, o_l, o_g, o_e, o_d},
          {28'd0, res == 0, res == 1, res == 2, 1'b1});
    check({tag, "_phase"}, 32'(o_phase), 32'd3);
    step();
    check({tag, "_hold"}, {28'd0, o_l, o_g, o_e, o_d},
          {28'd0, res == 0, res == 1, res == 2, 1'b1});
  endtask

  initial begin
    logic [11:0] ra, rb, mask;
    rst8 = 1'b1; rst12 = 1'b1; pb = 1'b0; y = 4'h0; sm = 1'b0;

    // Reset state
    select(8);
    check("reset_phase", 32'(o_phase), 32'd0);
    check("reset_flags", {28'd0, o_l, o_g, o_e, o_d}, 32'd0);

    // Equal operands, with pb toggling during the compare
    run_cmp("eq_d0", 12'h0D0, 12'h0D0, 1'b0, 1'b1, 1'b0);

    // Early termination, unsigned then signed
    run_cmp("uns_d0_3f", 12'h0D0, 12'h03F, 1'b0, 1'b0, 1'b0);
    run_cmp("sgn_d0_3f", 12'h0D0, 12'h03F, 1'b1, 1'b0, 1'b0);
    run_cmp("sgn_f0_f3", 12'h0F0, 12'h0F3, 1'b1, 1'b0, 1'b0);

    // A press in DONE clears the result and starts loading A
    press(4'h5, 1);
    check("done_press_phase", 32'(o_phase), 32'd0);
    check("done_press_flags", {28'd0, o_l, o_g, o_e, o_d}, 32'd0);
    run_cmp("after_done", 12'h05A, 12'h05B, 1'b0, 1'b0, 1'b1);

    // A held button counts once
    select(8);
    press(4'h9, 20);
    check("hold_phase", 32'(o_phase), 32'd0);
    run_cmp("hold", 12'h096, 12'h096, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of loading B
    select(8);
    press(4'h7, 1); press(4'h7, 1); press(4'h1, 1);
    check("midb_phase_pre", 32'(o_phase), 32'd1);
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    check("midrst_phase", 32'(o_phase), 32'd0);
    check("midrst_flags", {28'd0, o_l, o_g, o_e, o_d}, 32'd0);
    run_cmp("reload_12", 12'h012, 12'h012, 1'b0, 1'b0, 1'b0);

    // Randomised 8-bit
    mask = 12'h0FF;
    for (int it = 0; it < 20; it++) begin
      ra = 12'($urandom) & mask;
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = (ra & ~12'h00F) | (12'($urandom) & 12'h00F);
        default: rb = 12'($urandom) & mask;
      endcase
      run_cmp("rnd8", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // 12-bit instance
    select(12);
    check("reset12_phase", 32'(o_phase), 32'd0);
    run_cmp("abc_abd", 12'hABC, 12'hABD, 1'b0, 1'b1, 1'b0);
    run_cmp("s800_7ff", 12'h800, 12'h7FF, 1'b1, 1'b0, 1'b0);
    run_cmp("u800_7ff", 12'h800, 12'h7FF, 1'b0, 1'b0, 1'b0);

    mask = 12'hFFF;
    for (int it = 0; it < 20; it++) begin
      ra = 12'($urandom) & mask;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = (ra & ~12'h00F) | (12'($urandom) & 12'h00F);
        2:       rb = (ra & ~12'h0FF) | (12'($urandom) & 12'h0FF);
        default: rb = 12'($urandom) & mask;
      endcase
      run_cmp("rnd12", ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
